// File: rtl/io_fifo_peripheral_pkg.sv
// Shared definitions for io_fifo_peripheral: status byte layout, bus width,
// and the clog2 helper used to size FIFO pointers and counters.
package io_fifo_peripheral_pkg;

  localparam int unsigned DATA_W = 8;

  // Status byte bit positions
  localparam int unsigned ST_RX_NE     = 0;
  localparam int unsigned ST_TX_FULL   = 1;
  localparam int unsigned ST_TX_EMPTY  = 2;
  localparam int unsigned ST_RX_FULL   = 3;
  localparam int unsigned ST_RX_ERR    = 4;
  localparam int unsigned ST_TX_ERR    = 5;
  localparam int unsigned ST_IRQ_EN_RX = 6;
  localparam int unsigned ST_IRQ_EN_TX = 7;

  // Status byte, MSB first so the packed bit positions match the indices above
  typedef struct packed {
    logic irq_en_tx;
    logic irq_en_rx;
    logic tx_err;
    logic rx_err;
    logic rx_full;
    logic tx_empty;
    logic tx_full;
    logic rx_nonempty;
  } status_t;

  // Smallest r with 2**r >= v
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/io_fifo_peripheral_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO, 8-bit wide, DEPTH entries.
// Ports: clk, rst_n (async, active-low), push/wdata, pop/rdata (current head,
// 8'h00 when empty), full, empty, count (clog2(DEPTH)+1 bits).
// Push while full and pop while empty are ignored; flags come from the count
// register, so a simultaneous pop never makes room for a push into a full FIFO.
module sync_fifo
  import io_fifo_peripheral_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    pop,
  output logic [DATA_W-1:0]       rdata,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok_c, pop_ok_c;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state: pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    push_ok_c = push && !full;
    pop_ok_c  = pop && !empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/io_fifo_peripheral.sv
// io_fifo_peripheral: CPU I/O port pair (data + status/control) in front of a
// TX FIFO drained by a streaming device and an RX FIFO filled by one.
// Ports: clk, rst_n (async, active-low); cs_data/cs_stat/io_read/io_write CPU
// strobes; io_data/io_stat bidirectional 8-bit buses (driven only on reads);
// tx_data/tx_valid/tx_ready device TX stream; rx_data/rx_valid/rx_ready device
// RX stream; irq interrupt request.
// Build option: define IO_FIFO_IRQ_EN to enable the irq_en status bits and the
// registered irq output; otherwise irq is tied low and bits 6/7 read 0.
module io_fifo_peripheral
  import io_fifo_peripheral_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_data,
  input  logic              cs_stat,
  input  logic              io_read,
  input  logic              io_write,
  inout  wire  [DATA_W-1:0] io_data,
  inout  wire  [DATA_W-1:0] io_stat,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              irq
);

  localparam int unsigned CNT_W = clog2(DEPTH) + 1;

  logic              data_rd_c, data_wr_c, stat_rd_c, stat_wr_c;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_pop_c, rx_push_c, rx_pop_c;
  logic [CNT_W-1:0]  tx_count, rx_count;
  logic [DATA_W-1:0] rx_head;
  logic              rx_err_q, rx_err_d;
  logic              tx_err_q, tx_err_d;
  status_t           status;
  logic              unused_sig;

  // CPU access decode; a write strobe suppresses any bus drive
  assign data_rd_c = cs_data && io_read && !io_write;
  assign stat_rd_c = cs_stat && io_read && !io_write;
  assign data_wr_c = cs_data && io_write;
  assign stat_wr_c = cs_stat && io_write;

  // Device-side handshakes
  assign tx_valid  = !tx_empty;
  assign rx_ready  = !rx_full;
  assign tx_pop_c  = tx_valid && tx_ready;
  assign rx_push_c = rx_valid && rx_ready;
  assign rx_pop_c  = data_rd_c && !rx_empty;

  sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (data_wr_c),
    .wdata (io_data),
    .pop   (tx_pop_c),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push_c),
    .wdata (rx_data),
    .pop   (rx_pop_c),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Sticky errors: W1C first, then set, so a same-cycle set wins
  always_comb begin
    rx_err_d = rx_err_q;
    tx_err_d = tx_err_q;
    if (stat_wr_c) begin
      if (io_stat[ST_RX_ERR]) rx_err_d = 1'b0;
      if (io_stat[ST_TX_ERR]) tx_err_d = 1'b0;
    end
    if (data_rd_c && rx_empty) rx_err_d = 1'b1;
    if (data_wr_c && tx_full)  tx_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_err_q <= 1'b0;
      tx_err_q <= 1'b0;
    end else begin
      rx_err_q <= rx_err_d;
      tx_err_q <= tx_err_d;
    end
  end

`ifdef IO_FIFO_IRQ_EN
  logic irq_en_rx_q, irq_en_rx_d;
  logic irq_en_tx_q, irq_en_tx_d;
  logic irq_q, irq_d;

  // Interrupt enables and registered request (one cycle behind its cause)
  always_comb begin
    irq_en_rx_d = irq_en_rx_q;
    irq_en_tx_d = irq_en_tx_q;
    if (stat_wr_c) begin
      irq_en_rx_d = io_stat[ST_IRQ_EN_RX];
      irq_en_tx_d = io_stat[ST_IRQ_EN_TX];
    end
    irq_d = (!rx_empty && irq_en_rx_q) || (tx_empty && irq_en_tx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_rx_q <= 1'b0;
      irq_en_tx_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      irq_en_rx_q <= irq_en_rx_d;
      irq_en_tx_q <= irq_en_tx_d;
      irq_q       <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Status byte built from registered state only
  always_comb begin
    status             = '0;
    status.rx_nonempty = !rx_empty;
    status.tx_full     = tx_full;
    status.tx_empty    = tx_empty;
    status.rx_full     = rx_full;
    status.rx_err      = rx_err_q;
    status.tx_err      = tx_err_q;
`ifdef IO_FIFO_IRQ_EN
    status.irq_en_rx   = irq_en_rx_q;
    status.irq_en_tx   = irq_en_tx_q;
`endif
  end

  // Tri-state bus drive during read strobes
  assign io_data = data_rd_c ? rx_head : 8'bz;
  assign io_stat = stat_rd_c ? DATA_W'(status) : 8'bz;

  assign unused_sig = ^{tx_count, rx_count, io_stat};

endmodule

// File: tb/tb_io_fifo_peripheral.sv
module tb_io_fifo_peripheral;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_data, cs_stat, io_read, io_write;
  logic [7:0] d_drv, s_drv;
  logic       d_oe, s_oe;
  wire  [7:0] io_data;
  wire  [7:0] io_stat;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       irq;

  int errs   = 0;
  int checks = 0;
  int tx_got = 0;
  int tx_cnt_m = 0;
  int rx_cnt_m = 0;
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];

  assign io_data = d_oe ? d_drv : 8'bz;
  assign io_stat = s_oe ? s_drv : 8'bz;

  always #5 clk = ~clk;

  io_fifo_peripheral #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_data  (cs_data),
    .cs_stat  (cs_stat),
    .io_read  (io_read),
    .io_write (io_write),
    .io_data  (io_data),
    .io_stat  (io_stat),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .irq      (irq)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // TX scoreboard: the byte on tx_data when a device pop is about to occur
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        errs++;
        $error("FAIL tx_extra: observed %h expected no byte", tx_data);
      end else begin
        check("tx_order", tx_data, tx_q.pop_front());
        tx_cnt_m--;
      end
      tx_got++;
    end
  end

  // CPU write of one byte; starts and ends one time unit after a rising edge
  task automatic cpu_write(input bit stat, input logic [7:0] v);
    cs_data  = !stat;
    cs_stat  = stat;
    io_write = 1'b1;
    if (stat) begin s_drv = v; s_oe = 1'b1; end
    else      begin d_drv = v; d_oe = 1'b1; end
    if (!stat && tx_cnt_m < DEPTH) begin
      tx_q.push_back(v);
      tx_cnt_m++;
    end
    @(posedge clk); #1;
    cs_data = 1'b0; cs_stat = 1'b0; io_write = 1'b0;
    d_oe = 1'b0; s_oe = 1'b0;
  endtask

  task automatic stat_chk(input string tag, input logic [7:0] exp);
    cs_stat = 1'b1;
    io_read = 1'b1;
    @(negedge clk);
    check(tag, io_stat, exp);
    @(posedge clk); #1;
    cs_stat = 1'b0;
    io_read = 1'b0;
  endtask

  // One cycle with an optional CPU data read and/or device RX push
  task automatic cycle(input bit rd, input bit push, input logic [7:0] dv);
    logic [7:0] exp;
    bit acc;
    acc = (rx_cnt_m < DEPTH);
    if (rd)   begin cs_data = 1'b1; io_read = 1'b1; end
    if (push) begin rx_valid = 1'b1; rx_data = dv; end
    @(negedge clk);
    if (push) check("rx_ready", {7'd0, rx_ready}, {7'd0, acc});
    if (rd) begin
      if (rx_cnt_m > 0) begin exp = rx_q.pop_front(); rx_cnt_m--; end
      else exp = 8'h00;
      check("data_read", io_data, exp);
    end
    if (push && acc) begin rx_q.push_back(dv); rx_cnt_m++; end
    @(posedge clk); #1;
    cs_data = 1'b0; io_read = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic drain_tx(input string tag);
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && tx_valid; i++) begin
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    check(tag, {7'd0, tx_valid}, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    cs_data = 1'b0; cs_stat = 1'b0; io_read = 1'b0; io_write = 1'b0;
    d_drv = 8'h00; s_drv = 8'h00; d_oe = 1'b0; s_oe = 1'b0;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

    // Reset values
    #2;
    check("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    check("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    stat_chk("stat_after_reset", 8'h04);

    // TX overflow: fifth byte dropped, tx_err set
    cpu_write(0, 8'hA1);
    cpu_write(0, 8'hB2);
    cpu_write(0, 8'hC3);
    cpu_write(0, 8'hD4);
    cpu_write(0, 8'hE5);
    stat_chk("stat_tx_full_err", 8'h22);
    check("tx_valid_full", {7'd0, tx_valid}, 8'h01);
    check("tx_head", tx_data, 8'hA1);
    drain_tx("tx_drain1");
    check("tx_got4", 8'(tx_got), 8'd4);
    stat_chk("stat_tx_err_sticky", 8'h24);
    cpu_write(1, 8'h20);
    stat_chk("stat_tx_err_clr", 8'h04);

    // Read of an empty RX FIFO
    cycle(1, 0, 8'h00);
    stat_chk("stat_rx_err", 8'h14);
    cpu_write(1, 8'h10);
    stat_chk("stat_rx_err_clr", 8'h04);

    // Device push is visible the next cycle
    cycle(0, 1, 8'h5A);
    stat_chk("stat_rx_ne", 8'h05);
    cycle(1, 0, 8'h00);
    stat_chk("stat_rx_popped", 8'h04);

    // RX push + pop in one cycle, then full RX with pop + offered byte
    cycle(0, 1, 8'h11);
    cycle(0, 1, 8'h22);
    cycle(0, 1, 8'h33);
    cycle(1, 1, 8'h44);
    stat_chk("stat_rx_3", 8'h05);
    cycle(0, 1, 8'h55);
    stat_chk("stat_rx_full", 8'h0D);
    cycle(1, 1, 8'h66);
    cycle(1, 0, 8'h00);
    cycle(1, 0, 8'h00);
    cycle(1, 0, 8'h00);
    stat_chk("stat_rx_drained", 8'h04);

    // Full TX with a device pop and a CPU write in the same cycle
    cpu_write(0, 8'h01);
    cpu_write(0, 8'h02);
    cpu_write(0, 8'h03);
    cpu_write(0, 8'h04);
    tx_ready = 1'b1;
    cpu_write(0, 8'h05);
    drain_tx("tx_drain2");
    check("tx_got8", 8'(tx_got), 8'd8);
    stat_chk("stat_tx_full_pop_err", 8'h24);
    cpu_write(1, 8'h20);
    stat_chk("stat_tx_err_clr2", 8'h04);

`ifdef IO_FIFO_IRQ_EN
    // irq follows rx_nonempty with one cycle of lag
    cpu_write(1, 8'h40);
    stat_chk("stat_irq_en", 8'h44);
    check("irq_idle", {7'd0, irq}, 8'h00);
    cycle(0, 1, 8'h77);
    @(negedge clk);
    check("irq_lag", {7'd0, irq}, 8'h00);
    @(posedge clk); #1;
    @(negedge clk);
    check("irq_rise", {7'd0, irq}, 8'h01);
    @(posedge clk); #1;
    cycle(1, 0, 8'h00);
    @(negedge clk);
    check("irq_hold", {7'd0, irq}, 8'h01);
    @(posedge clk); #1;
    @(negedge clk);
    check("irq_fall", {7'd0, irq}, 8'h00);
    @(posedge clk); #1;
    cpu_write(1, 8'h00);
`else
    // Enable bits are absent: writes ignored, irq stays low
    cpu_write(1, 8'hC0);
    stat_chk("stat_irq_absent", 8'h04);
    cycle(0, 1, 8'h77);
    @(negedge clk);
    check("irq_tied", {7'd0, irq}, 8'h00);
    @(posedge clk); #1;
    cycle(1, 0, 8'h00);
`endif

    // Reset mid-transfer empties both FIFOs at once
    cpu_write(0, 8'hAA);
    cycle(0, 1, 8'hBB);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_irq", {7'd0, irq}, 8'h00);
    tx_q.delete(); rx_q.delete();
    tx_cnt_m = 0; rx_cnt_m = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    stat_chk("stat_after_mid_rst", 8'h04);
    cycle(1, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
